sram_port_arbiter: RTL and testbench

- Shares one single-port synchronous SRAM between the MiniMIPS32 instruction-fetch and data-access requesters.
- Arbitrates requests and applies the fixed kseg0/kseg1 virtual-to-physical mapping: addresses with top bits 3'b100 or 3'b101 have bits [31:29] cleared; all other addresses pass through unchanged.
- Returns read data to the requester that owns each access.
- Sits between the core and the unified on-chip SRAM in the single-port SoC build.

---
 rtl/sram_port_arbiter.sv | 93 +++++++++
 tb/tb_sram_port_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port SRAM between instruction fetch and data access.
// Rev 1.0 - kseg0/kseg1 mapping, data-priority arbitration with bounded instruction starvation.
`default_nettype none

module sram_port_arbiter #(
  parameter int MAX_DBURST = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr_v,
  output logic        inst_gnt,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr_v,
  input  logic [31:0] data_wdata,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_t;

  localparam logic [3:0] DMAX = 4'(MAX_DBURST);

  owner_t      owner;
  logic [3:0]  dcnt;
  logic [31:0] inst_hold;
  logic [31:0] data_hold;
  logic        inst_win;
  logic        data_win;

  // kseg0 (100) and kseg1 (101) both collapse onto physical low memory
  function automatic logic [31:0] kmap(input logic [31:0] a);
    kmap = (a[31:30] == 2'b10) ? {3'b000, a[28:0]} : a;
  endfunction

  assign inst_win = inst_req & (~data_req | (dcnt == DMAX));
  assign data_win = data_req & ~inst_win;

  assign inst_gnt   = resetn & inst_win;
  assign data_gnt   = resetn & data_win;
  assign sram_en    = inst_gnt | data_gnt;
  assign sram_addr  = inst_win ? kmap(inst_addr_v) : kmap(data_addr_v);
  assign sram_wen   = data_gnt ? data_wen : 4'b0000;
  assign sram_wdata = data_wdata;

  // Read data bypasses straight from the SRAM in the response cycle, then holds
  assign inst_rvalid = (owner == OWN_INST);
  assign data_rvalid = (owner == OWN_DATA);
  assign inst_rdata  = inst_rvalid ? sram_rdata : inst_hold;
  assign data_rdata  = data_rvalid ? sram_rdata : data_hold;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      owner     <= OWN_NONE;
      dcnt      <= 4'd0;
      inst_hold <= 32'd0;
      data_hold <= 32'd0;
    end else begin
      if (inst_gnt)
        owner <= OWN_INST;
      else if (data_gnt && (data_wen == 4'b0000))
        owner <= OWN_DATA;
      else
        owner <= OWN_NONE;

      if (!inst_req || inst_gnt)
        dcnt <= 4'd0;
      else if (data_gnt && (dcnt != DMAX))
        dcnt <= dcnt + 4'd1;

      if (inst_rvalid)
        inst_hold <= sram_rdata;
      if (data_rvalid)
        data_hold <= sram_rdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed stimulus with an SRAM model and read-data scoreboard.
// Rev 1.0
`default_nettype none

module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr_v;
  logic        inst_gnt;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr_v;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata = 32'd0;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] iq [$];
  logic [31:0] dq [$];
  logic        inst_due = 1'b0;
  logic        data_due = 1'b0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.MAX_DBURST(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr_v(inst_addr_v), .inst_gnt(inst_gnt),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wen(data_wen), .data_addr_v(data_addr_v),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .data_rdata(data_rdata),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  function automatic logic [31:0] map_addr(input logic [31:0] a);
    if (a[31:29] == 3'b100 || a[31:29] == 3'b101)
      return {3'b000, a[28:0]};
    return a;
  endfunction

  function automatic logic [31:0] rdfn(input logic [31:0] a);
    if (mem.exists(a))
      return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // SRAM model: one-cycle read latency, byte-enabled writes
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_wen == 4'b0000) begin
        sram_rdata <= rdfn(sram_addr);
      end else begin
        logic [31:0] w;
        w = rdfn(sram_addr);
        for (int b = 0; b < 4; b++)
          if (sram_wen[b]) w[8*b +: 8] = sram_wdata[8*b +: 8];
        mem[sram_addr] = w;
      end
    end
  end

  // Scoreboard: expected read data pushed from bench-driven addresses at grant
  always @(posedge clk) begin
    if (!resetn) begin
      iq.delete();
      dq.delete();
      inst_due <= 1'b0;
      data_due <= 1'b0;
    end else begin
      inst_due <= inst_gnt;
      data_due <= data_gnt && (data_wen == 4'b0000);
      if (inst_gnt)
        iq.push_back(rdfn(map_addr(inst_addr_v)));
      if (data_gnt && (data_wen == 4'b0000))
        dq.push_back(rdfn(map_addr(data_addr_v)));
    end
  end

  always @(negedge clk) begin
    chk("inst_rvalid", {31'd0, inst_rvalid}, {31'd0, inst_due});
    chk("data_rvalid", {31'd0, data_rvalid}, {31'd0, data_due});
    if (inst_due && iq.size() > 0)
      chk("inst_rdata_sb", inst_rdata, iq.pop_front());
    if (data_due && dq.size() > 0)
      chk("data_rdata_sb", data_rdata, dq.pop_front());
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mem[32'h1FC0_0000] = 32'h3C1D_0001;
    resetn      = 1'b0;
    inst_req    = 1'b1;
    data_req    = 1'b1;
    inst_addr_v = 32'hBFC0_0000;
    data_addr_v = 32'h8000_1234;
    data_wen    = 4'b0000;
    data_wdata  = 32'd0;

    // Reset held with both requests high
    repeat (3) begin
      @(negedge clk);
      chk("rst_sram_en", {31'd0, sram_en}, 32'd0);
      chk("rst_inst_gnt", {31'd0, inst_gnt}, 32'd0);
      chk("rst_data_gnt", {31'd0, data_gnt}, 32'd0);
    end
    chk("rst_inst_rdata", inst_rdata, 32'd0);
    chk("rst_data_rdata", data_rdata, 32'd0);

    // Release with only the instruction side requesting
    @(posedge clk); #1;
    resetn = 1'b1; data_req = 1'b0;
    @(negedge clk);
    chk("inst_gnt_first", {31'd0, inst_gnt}, 32'd1);
    chk("inst_only_dgnt", {31'd0, data_gnt}, 32'd0);
    chk("inst_sram_en", {31'd0, sram_en}, 32'd1);
    chk("inst_map_addr", sram_addr, 32'h1FC0_0000);
    chk("inst_sram_wen", {28'd0, sram_wen}, 32'd0);
    @(posedge clk); #1;
    inst_req = 1'b0;
    @(negedge clk);
    chk("inst_rdata_n1", inst_rdata, 32'h3C1D_0001);
    repeat (4) begin
      @(negedge clk);
      chk("inst_rdata_hold", inst_rdata, 32'h3C1D_0001);
    end

    // Data reads, back to back: kseg0 mapped then untranslated
    @(posedge clk); #1;
    data_req = 1'b1; data_addr_v = 32'h8000_1234;
    @(negedge clk);
    chk("dmap_gnt", {31'd0, data_gnt}, 32'd1);
    chk("dmap_kseg0", sram_addr, 32'h0000_1234);
    @(posedge clk); #1;
    data_addr_v = 32'h4000_0010;
    @(negedge clk);
    chk("dmap_gnt2", {31'd0, data_gnt}, 32'd1);
    chk("dmap_plain", sram_addr, 32'h4000_0010);
    @(posedge clk); #1;
    data_req = 1'b0;
    @(negedge clk);

    // Partial write, then read back
    @(posedge clk); #1;
    data_req = 1'b1; data_wen = 4'b0011;
    data_addr_v = 32'h8000_0020; data_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("wr_gnt", {31'd0, data_gnt}, 32'd1);
    chk("wr_sram_wen", {28'd0, sram_wen}, 32'h3);
    chk("wr_sram_addr", sram_addr, 32'h0000_0020);
    chk("wr_sram_wdata", sram_wdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    data_req = 1'b0; data_wen = 4'b0000;
    @(negedge clk);
    chk("wr_no_rvalid", {31'd0, data_rvalid}, 32'd0);
    @(posedge clk); #1;
    data_req = 1'b1;
    @(posedge clk); #1;
    data_req = 1'b0;
    @(negedge clk);
    chk("wr_readback", data_rdata, 32'h5A5A_BEEF);

    // Starvation bound: D D D D I D D D D I
    @(posedge clk); #1;
    inst_req = 1'b1; inst_addr_v = 32'h8000_0100;
    data_req = 1'b1; data_addr_v = 32'h0000_0200;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("starve_gnt_%0d", k), {30'd0, inst_gnt, data_gnt},
          (k == 4 || k == 9) ? 32'h2 : 32'h1);
    end
    @(posedge clk); #1;
    inst_req = 1'b0; data_req = 1'b0;
    @(negedge clk);

    // Reset sampled right after a data read grant drops the response
    @(posedge clk); #1;
    data_req = 1'b1; data_addr_v = 32'h8000_0300;
    @(negedge clk);
    chk("midrst_gnt", {31'd0, data_gnt}, 32'd1);
    #1 resetn = 1'b0;
    @(negedge clk);
    chk("midrst_no_rvalid", {31'd0, data_rvalid}, 32'd0);
    chk("midrst_data_rdata", data_rdata, 32'd0);
    chk("midrst_inst_rdata", inst_rdata, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1; data_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
